ca_row_engine: RTL and testbench

- Pixel-generation stage directly downstream of the 1280x1024 sync generator. Consumes its prefetch-area flag, prefetch X counter and Y counter.
- Renders a 1D elementary cellular automaton: screen row y shows generation y, computed on the fly from row y-1.
- Row storage is two 1280x1 ping-pong line RAMs. Seeding happens during vertical blanking.
- Output is a single pixel bit that is aligned to the display area when the sync generator's FRONT_MARGIN equals LATENCY.

---
 rtl/ca_pkg.sv | 28 ++
 rtl/ca_row_engine_if.sv | 22 ++
 rtl/ca_line_ram.sv | 19 +
 rtl/ca_row_engine.sv | 124 ++++++++++++
 tb/tb_ca_row_engine.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/ca_pkg.sv
// Shared constants and types for the cellular-automaton row engine.
package ca_pkg;
   localparam logic [10:0] H_VISIBLE = 11'd1280;
   localparam logic [10:0] H_LAST    = H_VISIBLE - 11'd1;
   localparam logic [10:0] V_VISIBLE = 11'd1024;
   localparam logic [10:0] SEED_POS  = 11'd640;
   localparam int          LATENCY   = 3;

   // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS    = 16'h002D;
   localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

   typedef enum logic [1:0] {
      SEED_SINGLE = 2'd0,
      SEED_LFSR   = 2'd1,
      SEED_ONES   = 2'd2
   } seed_mode_e;

   typedef enum logic [1:0] {
      WAIT_INIT = 2'd0,
      INIT      = 2'd1,
      RUN       = 2'd2
   } state_e;

   function automatic logic [15:0] lfsrStep(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction
endpackage

// File: rtl/ca_row_engine_if.sv
// Sync-generator inputs, rule configuration and pixel outputs of the row engine.
interface ca_row_engine_if;
   logic        in_prefetch_area;
   logic [10:0] prefetch_x;
   logic [10:0] counter_y;
   logic [7:0]  rule;
   logic [1:0]  seed_mode;
   logic [15:0] lfsr_seed;
   logic        pixel_on;
   logic        pixel_valid;
   logic        init_busy;

   modport master (
      output in_prefetch_area, prefetch_x, counter_y, rule, seed_mode, lfsr_seed,
      input  pixel_on, pixel_valid, init_busy
   );

   modport slave (
      input  in_prefetch_area, prefetch_x, counter_y, rule, seed_mode, lfsr_seed,
      output pixel_on, pixel_valid, init_busy
   );
endinterface

// File: rtl/ca_line_ram.sv
// One 1280x1 line buffer: simple dual-port, synchronous read, contents never reset.
module ca_line_ram
   import ca_pkg::*;
(
   input  logic        clk,
   input  logic        wrEn,
   input  logic [10:0] wrAddr,
   input  logic        wrData,
   input  logic        rdEn,
   input  logic [10:0] rdAddr,
   output logic        rdData
);
   logic mem [0:H_VISIBLE-1];

   always_ff @(posedge clk) begin
      if (wrEn) mem[wrAddr] <= wrData;
      if (rdEn) rdData <= mem[rdAddr];
   end
endmodule

// File: rtl/ca_row_engine.sv
// Renders one elementary-CA generation per screen row from two ping-pong line buffers.
//
// state     | meaning
// WAIT_INIT | after reset, nothing displayed until first vertical-blank seeding
// INIT      | writing seed row into bank 0, one cell per clock
// RUN       | reading row from bank bufSel, writing next generation into the other bank
module ca_row_engine
   import ca_pkg::*;
(
   input logic            clk,
   input logic            rst_n,
   ca_row_engine_if.slave bus
);
   state_e             state;
   seed_mode_e         seedLat;
   logic [7:0]         ruleLat;
   logic [15:0]        lfsr;
   logic [10:0]        initAddr, x1, x2;
   logic               bufSel, ready, areaD, atVD, fallD, cReg, lReg;
   logic [LATENCY-2:0] vPipe;

   logic        qual, atV, initTrig, initWr, runWr;
   logic        rdCell0, rdCell1, rdCell, cellL, cellR, nextCell, seedBit;
   logic        we0, we1, wd0;
   logic [10:0] wa0;

   assign qual     = bus.in_prefetch_area && (bus.prefetch_x < H_VISIBLE);
   assign atV      = (bus.counter_y == V_VISIBLE);
   assign initTrig = atV && ((state == WAIT_INIT) || ((state == RUN) && !atVD));
   assign initWr   = (state == INIT);

   // Window for cell x2: lReg = x-1, cReg = x, fresh read data = x+1.
   assign rdCell   = bufSel ? rdCell1 : rdCell0;
   assign cellL    = (x2 == 11'd0) ? 1'b0 : lReg;
   assign cellR    = (x2 == H_LAST) ? 1'b0 : rdCell;
   assign nextCell = ruleLat[{cellL, cReg, cellR}];
   assign runWr    = vPipe[LATENCY-2] && ready && !initTrig;

   always_comb begin
      seedBit = (initAddr == SEED_POS);
      case (seedLat)
         SEED_LFSR: seedBit = lfsr[0];
         SEED_ONES: seedBit = 1'b1;
         default:   ;
      endcase
   end

   assign we0 = initWr || (runWr && bufSel);
   assign wd0 = initWr ? seedBit : nextCell;
   assign wa0 = initWr ? initAddr : x2;
   assign we1 = runWr && !bufSel;

   ca_line_ram ram0 (
      .clk(clk), .wrEn(we0), .wrAddr(wa0), .wrData(wd0),
      .rdEn(qual), .rdAddr(bus.prefetch_x), .rdData(rdCell0)
   );

   ca_line_ram ram1 (
      .clk(clk), .wrEn(we1), .wrAddr(x2), .wrData(nextCell),
      .rdEn(qual), .rdAddr(bus.prefetch_x), .rdData(rdCell1)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= WAIT_INIT;
         seedLat         <= SEED_SINGLE;
         ruleLat         <= 8'd0;
         lfsr            <= LFSR_DEFAULT;
         initAddr        <= 11'd0;
         x1              <= 11'd0;
         x2              <= 11'd0;
         bufSel          <= 1'b0;
         ready           <= 1'b0;
         areaD           <= 1'b0;
         atVD            <= 1'b0;
         fallD           <= 1'b0;
         cReg            <= 1'b0;
         lReg            <= 1'b0;
         vPipe           <= '0;
         bus.pixel_on    <= 1'b0;
         bus.pixel_valid <= 1'b0;
         bus.init_busy   <= 1'b0;
      end else begin
         areaD <= bus.in_prefetch_area;
         atVD  <= atV;
         // Delayed one clock so the swap lands on/after the last row write.
         fallD <= areaD && !bus.in_prefetch_area && (bus.counter_y < V_VISIBLE);
         vPipe <= {vPipe[LATENCY-3:0], qual};
         x1    <= bus.prefetch_x;
         x2    <= x1;
         cReg  <= rdCell;
         lReg  <= cReg;

         bus.pixel_valid <= vPipe[LATENCY-2] && ready;
         bus.pixel_on    <= vPipe[LATENCY-2] && ready && cReg;

         if (initTrig)   bufSel <= 1'b0;
         else if (fallD) bufSel <= ~bufSel;

         if (initTrig) begin
            state         <= INIT;
            initAddr      <= 11'd0;
            ruleLat       <= bus.rule;
            seedLat       <= (bus.seed_mode == 2'd3) ? SEED_SINGLE : seed_mode_e'(bus.seed_mode);
            lfsr          <= (bus.lfsr_seed == 16'd0) ? LFSR_DEFAULT : bus.lfsr_seed;
            ready         <= 1'b0;
            bus.init_busy <= 1'b1;
         end else begin
            case (state)
               INIT: begin
                  lfsr     <= lfsrStep(lfsr);
                  initAddr <= initAddr + 11'd1;
                  if (initAddr == H_LAST) begin
                     state         <= RUN;
                     ready         <= 1'b1;
                     bus.init_busy <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ca_row_engine.sv
// Randomized bench for ca_row_engine against an array-based generation model.
module tb_ca_row_engine;
   localparam int W = 1280;

   logic clk = 1'b0;
   logic rst_n;

   ca_row_engine_if bus();

   ca_row_engine dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int         nChecks = 0;
   int         nPass = 0;
   bit         cur [W];
   bit         obsRow [W];
   int         dly [3];
   bit         readyExp;
   int         pixErr;
   int         busyCnt;
   logic [7:0] frameRule;

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: sample outputs due now, then drive the next prefetch inputs.
   task automatic cycleStep(input bit area, input int x, input int y);
      @(negedge clk);
      if (dly[2] >= 0) obsRow[dly[2]] = bus.pixel_on;
      if (bus.pixel_valid !== ((dly[2] >= 0) ? 1'b1 : 1'b0)) pixErr++;
      if (!readyExp && bus.pixel_on !== 1'b0) pixErr++;
      if (bus.init_busy === 1'b1) busyCnt++;
      dly[2] = dly[1];
      dly[1] = dly[0];
      dly[0] = (area && x < W && readyExp) ? x : -1;
      bus.in_prefetch_area = area;
      bus.prefetch_x       = 11'(x);
      bus.counter_y        = 11'(y);
   endtask

   task automatic doInit(input logic [7:0] r, input logic [1:0] sm, input logic [15:0] s);
      logic [15:0] l;
      logic        fb;
      bus.rule      = r;
      bus.seed_mode = sm;
      bus.lfsr_seed = s;
      frameRule     = r;
      busyCnt       = 0;
      pixErr        = 0;
      for (int i = 0; i < 1300; i++) cycleStep(1'b0, 0, 1024);
      checkEq("init_busy_len", 64'(busyCnt), 64'd1280);
      checkEq("init_quiet", 64'(pixErr), 64'd0);
      l = (s == 16'd0) ? 16'hACE1 : s;
      for (int x = 0; x < W; x++) begin
         case (sm)
            2'd1: begin
               cur[x] = l[0];
               fb = l[0] ^ l[2] ^ l[3] ^ l[5];
               l  = {fb, l[15:1]};
            end
            2'd2:    cur[x] = 1'b1;
            default: cur[x] = (x == 640);
         endcase
      end
      readyExp = 1'b1;
   endtask

   task automatic doRow(input int y, input int rstAt);
      bit          checkRow;
      bit          nxt [W];
      logic [63:0] o, e;
      int          idx;
      checkRow = readyExp && (rstAt < 0);
      pixErr   = 0;
      for (int i = 0; i < W; i++) obsRow[i] = 1'b0;
      for (int c = 0; c < 1292; c++) begin
         cycleStep(c < 1284, c, y);
         if (c == rstAt) begin
            rst_n = 1'b0;
            #1;
            checkEq("rst_async_pixel_on", 64'(bus.pixel_on), 64'd0);
            checkEq("rst_async_pixel_valid", 64'(bus.pixel_valid), 64'd0);
            readyExp = 1'b0;
            dly = '{-1, -1, -1};
         end
         if (rstAt >= 0 && c == rstAt + 3) rst_n = 1'b1;
      end
      if (checkRow) begin
         for (int c = 0; c < W / 64; c++) begin
            for (int b = 0; b < 64; b++) begin
               o[b] = obsRow[c * 64 + b];
               e[b] = cur[c * 64 + b];
            end
            checkEq($sformatf("row%0d_w%0d", y, c), o, e);
         end
      end
      checkEq($sformatf("row%0d_timing", y), 64'(pixErr), 64'd0);
      for (int x = 0; x < W; x++) begin
         idx = ((x == 0) ? 0 : 4 * int'(cur[x - 1])) + 2 * int'(cur[x]) +
               ((x == W - 1) ? 0 : int'(cur[x + 1]));
         nxt[x] = frameRule[idx];
      end
      cur = nxt;
   endtask

   task automatic runFrame(input logic [7:0] r, input logic [1:0] sm, input logic [15:0] s,
                           input int nRows, input int chgRow, input logic [7:0] chgRule,
                           input int rstRow);
      doInit(r, sm, s);
      for (int k = 0; k < nRows; k++) begin
         if (k == chgRow) bus.rule = chgRule;
         if (k == rstRow)      doRow(500, 600);
         else if (k == chgRow) doRow(300, -1);
         else                  doRow(k, -1);
      end
   endtask

   initial begin
      rst_n                = 1'b0;
      bus.in_prefetch_area = 1'b0;
      bus.prefetch_x       = 11'd0;
      bus.counter_y        = 11'd0;
      bus.rule             = 8'd0;
      bus.seed_mode        = 2'd0;
      bus.lfsr_seed        = 16'd0;
      dly                  = '{-1, -1, -1};
      readyExp             = 1'b0;
      frameRule            = 8'd0;
      repeat (3) @(negedge clk);
      checkEq("reset_pixel_on", 64'(bus.pixel_on), 64'd0);
      checkEq("reset_pixel_valid", 64'(bus.pixel_valid), 64'd0);
      checkEq("reset_init_busy", 64'(bus.init_busy), 64'd0);
      rst_n = 1'b1;

      doRow(5, -1);
      runFrame(8'd90,  2'd0, 16'd0, 3, -1, 8'd0, -1);
      runFrame(8'd204, 2'd2, 16'd0, 3, -1, 8'd0, -1);
      runFrame(8'd240, 2'd2, 16'd0, 4, -1, 8'd0, -1);
      runFrame(8'd0,   2'd1, 16'd0, 3, -1, 8'd0, -1);
      runFrame(8'd90,  2'd0, 16'd0, 4, 2, 8'd30, -1);
      runFrame(8'd30,  2'd3, 16'd0, 3, -1, 8'd0, 1);
      runFrame(8'd30,  2'd0, 16'd0, 2, -1, 8'd0, -1);
      repeat (3)
         runFrame(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 16'($urandom),
                  3, -1, 8'd0, -1);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
